operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: ZERO_REG_HARDWIRED, default 1, operand reads of register 0 return 0 regardless of register-file content.
REQ-002 Parameter: STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 w_in_valid  input  1  decoded instruction present.
REQ-006 w_in_ready  output  1  instruction accepted this cycle when high with w_in_valid.
REQ-007 w_in_rs_5 / w_in_rt_5 / w_in_rd_5  input  5 each  source 1, source 2, destination register numbers.
REQ-008 w_in_writes  input  1  instruction writes w_in_rd_5.
REQ-009 w_address_s1_5 / w_address_s2_5  output  5 each  register-file read addresses.
REQ-010 w_data_s1val_32 / w_data_s2val_32  input  32 each  register-file read data, combinational from the addresses.
REQ-011 w_wb_valid, w_wb_address_5, w_wb_data_32  input  1/5/32  retiring writeback.
REQ-012 w_address_d_5, w_data_dval_32, w_write_enable  output  5/32/1  register-file write port.
REQ-013 w_out_valid, w_out_ready  output/input  1/1  operand handshake to execute.
REQ-014 w_out_s1_32, w_out_s2_32  output  32 each  resolved operands.
REQ-015 w_out_rd_5, w_out_writes  output  5/1  destination carried with operands.
REQ-016 w_stall_count  output  STALL_CNT_W  hazard-stall cycles since reset.

Function
REQ-017 Read addresses SHALL equal w_in_rs_5 / w_in_rt_5 combinationally.
REQ-018 Write port SHALL be combinational pass-through: w_address_d_5 = w_wb_address_5, w_data_dval_32 = w_wb_data_32, w_write_enable = w_wb_valid and address != 0.
REQ-019 Scoreboard: 32-bit busy vector; bit 0 never set.
REQ-020 Hazard when w_in_valid and any of busy[rs], busy[rt], or (w_in_writes and busy[rd]), excluding a bit cleared by w_wb_valid in the same cycle.
REQ-021 w_in_ready = no hazard and (w_out_valid = 0 or w_out_ready = 1).
REQ-022 On accept: output register loads operands, rd, writes; w_out_valid = 1 next cycle (latency 1); if w_in_writes and rd != 0, busy[rd] set.
REQ-023 Forwarding: source equal to w_wb_address_5 with w_wb_valid and address != 0 SHALL take w_wb_data_32 instead of register-file data.
REQ-024 Source address 0 SHALL yield 0 when ZERO_REG_HARDWIRED = 1.
REQ-025 w_wb_valid clears busy[w_wb_address_5]; same-cycle set and clear of one bit: set wins.
REQ-026 Output held stable while w_out_valid = 1 and w_out_ready = 0; w_out_valid drops after handshake if no new accept.
REQ-027 w_stall_count increments each cycle w_in_valid = 1 with hazard; saturates at all-ones.

Reset
REQ-028 reset_n low SHALL asynchronously clear busy vector, w_out_valid, w_out_s1_32, w_out_s2_32, w_out_rd_5, w_out_writes, w_stall_count to 0.
REQ-029 Reset mid-operation SHALL discard the held instruction and all pending busy bits; no write port state is held.

Structure
REQ-030 Shared package SHALL hold register-number width (5), data width (32), and register count (32).
REQ-031 One sub-module, reg_scoreboard (busy vector, set/clear, hazard lookup), SHALL be instantiated; remainder flat.

Verification
REQ-032 Reset, then rs=3, rt=4, register file holding 3/4 -> next cycle out_valid=1, s1=3, s2=4.
REQ-033 Accept rd=5 writes=1; next instruction rs=5 -> in_ready=0, stall_count increments until wb_valid addr=5 data=0xABCD, which forwards s1=0xABCD same cycle.
REQ-034 rs=0, register file entry 0 forced to 0x1234 -> s1=0; wb to address 0 -> write_enable=0.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next instruction accepted.
REQ-036 Same cycle: wb clears reg 7 and new accept rd=7 -> busy[7]=1 afterwards.
REQ-037 reset_n low while busy[9]=1 and out_valid=1 -> both 0 immediately; instruction rs=9 accepted next cycle.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths and counts for the operand fetch stage.
package operand_fetch_pkg;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy-register scoreboard: pending writes and hazard lookup.
module reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             rd_check,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_addr,
    output logic             hazard
);
    logic [REG_CNT-1:0] busy;
    logic [REG_CNT-1:0] busy_nxt;
    logic [REG_CNT-1:0] clr_mask;
    logic [REG_CNT-1:0] set_mask;
    logic [REG_CNT-1:0] live;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        if (set_en) set_mask[set_addr] = 1'b1;
        // A retiring write hides its own busy bit in the same cycle.
        live     = busy & ~clr_mask;
        hazard   = live[rs] | live[rt] | (rd_check & live[rd]);
        busy_nxt = live | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_nxt;
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read, forwarding, hazard stall, output reg.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter bit ZERO_REG_HARDWIRED = 1'b1,
    parameter int STALL_CNT_W        = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   w_in_valid,
    output logic                   w_in_ready,
    input  logic [REG_W-1:0]       w_in_rs_5,
    input  logic [REG_W-1:0]       w_in_rt_5,
    input  logic [REG_W-1:0]       w_in_rd_5,
    input  logic                   w_in_writes,
    output logic [REG_W-1:0]       w_address_s1_5,
    output logic [REG_W-1:0]       w_address_s2_5,
    input  logic [DATA_W-1:0]      w_data_s1val_32,
    input  logic [DATA_W-1:0]      w_data_s2val_32,
    input  logic                   w_wb_valid,
    input  logic [REG_W-1:0]       w_wb_address_5,
    input  logic [DATA_W-1:0]      w_wb_data_32,
    output logic [REG_W-1:0]       w_address_d_5,
    output logic [DATA_W-1:0]      w_data_dval_32,
    output logic                   w_write_enable,
    output logic                   w_out_valid,
    input  logic                   w_out_ready,
    output logic [DATA_W-1:0]      w_out_s1_32,
    output logic [DATA_W-1:0]      w_out_s2_32,
    output logic [REG_W-1:0]       w_out_rd_5,
    output logic                   w_out_writes,
    output logic [STALL_CNT_W-1:0] w_stall_count
);
    logic              wb_live;
    logic              sb_hazard;
    logic              hazard;
    logic              accept;
    logic              set_en;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;

    assign w_address_s1_5 = w_in_rs_5;
    assign w_address_s2_5 = w_in_rt_5;

    assign wb_live        = w_wb_valid && (w_wb_address_5 != '0);
    assign w_address_d_5  = w_wb_address_5;
    assign w_data_dval_32 = w_wb_data_32;
    assign w_write_enable = wb_live;

    reg_scoreboard u_sb (
        .clock    (clock),
        .reset_n  (reset_n),
        .rs       (w_in_rs_5),
        .rt       (w_in_rt_5),
        .rd       (w_in_rd_5),
        .rd_check (w_in_writes),
        .set_en   (set_en),
        .set_addr (w_in_rd_5),
        .clr_en   (w_wb_valid),
        .clr_addr (w_wb_address_5),
        .hazard   (sb_hazard)
    );

    assign hazard     = w_in_valid && sb_hazard;
    assign w_in_ready = !hazard && (!w_out_valid || w_out_ready);
    assign accept     = w_in_valid && w_in_ready;
    assign set_en     = accept && w_in_writes && (w_in_rd_5 != '0);

    always_comb begin
        s1 = w_data_s1val_32;
        s2 = w_data_s2val_32;
        if (wb_live && (w_wb_address_5 == w_in_rs_5)) s1 = w_wb_data_32;
        if (wb_live && (w_wb_address_5 == w_in_rt_5)) s2 = w_wb_data_32;
        if (ZERO_REG_HARDWIRED && (w_in_rs_5 == '0)) s1 = '0;
        if (ZERO_REG_HARDWIRED && (w_in_rt_5 == '0)) s2 = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_out_valid  <= 1'b0;
            w_out_s1_32  <= '0;
            w_out_s2_32  <= '0;
            w_out_rd_5   <= '0;
            w_out_writes <= 1'b0;
        end else if (accept) begin
            w_out_valid  <= 1'b1;
            w_out_s1_32  <= s1;
            w_out_s2_32  <= s2;
            w_out_rd_5   <= w_in_rd_5;
            w_out_writes <= w_in_writes;
        end else if (w_out_ready) begin
            w_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_stall_count <= '0;
        end else if (hazard && !(&w_stall_count)) begin
            w_stall_count <= w_stall_count + 1'b1;
        end
    end
endmodule
